// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetcher: streams FB_WORDS pixel words from memory into a small
// show-ahead FIFO feeding the display, with restart and in-flight response dropping.
module vga_pixel_fetch #(
    parameter int FB_WORDS   = 307200,
    parameter int FIFO_DEPTH = 16,
    localparam int CW = $clog2(FIFO_DEPTH + 1),
    localparam int PW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_restart,
    input  logic          pix_ready,
    output logic [31:0]   pix_data,
    output logic          pix_valid,
    output logic          underflow,
    output logic          mem_req,
    output logic [18:0]   mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    dbg_state,
    output logic [CW-1:0] dbg_fifo_count
);

    // Handshakes: a memory request transfers when mem_req && mem_gnt; a pixel
    // transfers when pix_ready && pix_valid. Once raised, mem_req and mem_addr
    // hold until the transfer, unless frame_restart abandons the request.
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CW:0]  DEPTH_W   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [18:0]  LAST_ADDR = 19'(FB_WORDS - 1);

    state_t        state;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   credit_sum;
    logic          accept;
    logic          live_ret;
    logic          discard;
    logic          push;
    logic          pop;

    // Responses still due for discard also hold a credit, so the total in flight
    // never exceeds FIFO_DEPTH and every counter stays within 0..FIFO_DEPTH.
    always_comb begin
        credit_sum = {1'b0, fifo_count} + {1'b0, live_cnt} + {1'b0, drop_cnt};
        mem_req    = (state == FETCH) && !frame_restart && (credit_sum < DEPTH_W);
        accept     = mem_req && mem_gnt;
        live_ret   = mem_rvalid && (drop_cnt == '0);
        discard    = mem_rvalid && (drop_cnt != '0);
        push       = live_ret && !frame_restart;
        pix_valid  = (fifo_count != '0);
        pop        = pix_ready && pix_valid && !frame_restart;
        pix_data   = pix_valid ? fifo_mem[rd_ptr] : '0;
    end

    assign dbg_state      = state;
    assign dbg_fifo_count = fifo_count;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            live_cnt   <= '0;
            drop_cnt   <= '0;
            underflow  <= 1'b0;
        end else begin
            if (pix_ready && !pix_valid) begin
                underflow <= 1'b1;
            end
            if (frame_restart) begin
                state      <= FETCH;
                mem_addr   <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                live_cnt   <= '0;
                // everything in flight except a response landing right now
                drop_cnt   <= drop_cnt + live_cnt - {{(CW - 1){1'b0}}, mem_rvalid};
            end else begin
                case (state)
                    FETCH: begin
                        if (accept) begin
                            if (mem_addr == LAST_ADDR) begin
                                state <= DONE;
                            end else begin
                                mem_addr <= mem_addr + 1'b1;
                            end
                        end
                    end
                    default: state <= state;
                endcase
                if (accept && !live_ret) begin
                    live_cnt <= live_cnt + 1'b1;
                end else if (!accept && live_ret) begin
                    live_cnt <= live_cnt - 1'b1;
                end
                if (discard) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    fifo_count <= fifo_count + 1'b1;
                end else if (pop && !push) begin
                    fifo_count <= fifo_count - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter FB_WORDS, default 307200, meaning the number of 32-bit pixel words per frame (640x480).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the prefetch FIFO entries (power of two, at least 4).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port frame_restart, input, 1, a one-cycle pulse that begins a new frame fetch from word 0.
REQ-006 SHALL have port pix_ready, input, 1, where the display consumes the head pixel this cycle (driven by display data_enable).
REQ-007 SHALL have port pix_data, output, 32, the FIFO head word, show-ahead, {8'x, R, G, B}.
REQ-008 SHALL have port pix_valid, output, 1, high when the FIFO is non-empty.
REQ-009 SHALL have port underflow, output, 1, a sticky flag set when pix_ready arrives while the FIFO is empty.
REQ-010 SHALL have port mem_req, output, 1, a framebuffer read request.
REQ-011 SHALL have port mem_addr, output, 19, the framebuffer word address.
REQ-012 SHALL have port mem_gnt, input, 1; a request is accepted in any cycle with mem_req and mem_gnt both high.
REQ-013 SHALL have port mem_rvalid, input, 1, which returns exactly one in-order response per accepted request, at least 1 cycle after acceptance.
REQ-014 SHALL have port mem_rdata, input, 32, the read data, qualified by mem_rvalid.

Function
REQ-015 SHALL implement states IDLE, FETCH and DONE.
- IDLE to FETCH on frame_restart.
- FETCH to DONE when request FB_WORDS-1 is accepted.
- DONE to FETCH on frame_restart.
- frame_restart in FETCH restarts FETCH.
REQ-016 SHALL, on frame_restart, set mem_addr to 0, empty the FIFO and hold mem_req low that cycle, abandoning any ungranted request.
REQ-017 SHALL, on frame_restart, load drop_cnt with the in-flight responses not returning that cycle.
- Each later mem_rvalid with drop_cnt>0 decrements drop_cnt and is discarded, not written to the FIFO.
REQ-018 SHALL assert mem_req only in FETCH, outside a frame_restart cycle, and only when fifo_count + live_outstanding < FIFO_DEPTH.
- live_outstanding counts accepted, undiscarded, not-yet-returned requests.
REQ-019 SHALL, once mem_req is asserted, hold mem_req high and mem_addr stable until accepted, except per REQ-016.
REQ-020 SHALL increment mem_addr by 1 on each acceptance; mem_addr SHALL never exceed FB_WORDS-1 and SHALL not wrap within a frame.
REQ-021 SHALL write mem_rdata into the FIFO on a non-discarded mem_rvalid and pop the head on pix_ready while pix_valid.
- A simultaneous push and pop leaves fifo_count unchanged.
- A push that would overflow is impossible by REQ-018.
REQ-022 SHALL present pix_data and pix_valid as registered or FIFO-head outputs, with a new word visible 1 cycle after its mem_rvalid when the FIFO was empty.
REQ-023 SHALL set underflow on pix_ready with pix_valid low; that event SHALL change no other state; underflow clears only on rst.
REQ-024 SHALL size counters for 0..FIFO_DEPTH inclusive with no wrap.

Reset
REQ-025 SHALL, on rst, force state to IDLE and set mem_req=0, mem_addr=0, fifo_count=0, drop_cnt=0, live_outstanding=0, pix_valid=0, underflow=0 and pix_data=0.
REQ-026 SHALL, for rst asserted mid-frame, discard in-flight responses; the memory side is reset by the same rst.

Verification
REQ-027 SHALL cover fill: rst, frame_restart, mem_gnt=1, 2-cycle read latency, pix_ready=0 -> exactly 16 requests at addresses 0..15, then mem_req=0 and pix_valid=1 with pix_data equal to word 0.
REQ-028 SHALL cover streaming: continuous pix_ready at full bandwidth with a 1-cycle latency memory -> pixels in address order, underflow=0, DONE after address 307199, and no request beyond 307199.
REQ-029 SHALL cover a held request: mem_gnt=0 for 5 cycles -> mem_req held high with mem_addr constant for all 5 cycles, and acceptance on the first mem_gnt=1.
REQ-030 SHALL cover restart with 3 outstanding: frame_restart -> next 3 rvalids discarded, FIFO empty, next request at address 0, first delivered pixel is word 0.
REQ-031 SHALL cover underflow: pix_ready=1 with an empty FIFO -> underflow=1 next cycle, remaining set after data arrives, cleared only by rst.
REQ-032 SHALL cover a simultaneous push and pop with fifo_count=FIFO_DEPTH-1 -> count stays FIFO_DEPTH-1 and FIFO order is preserved.
